ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RISC-V pipeline. It accepts decoded operands from the ID/EX boundary and computes the ALU result in one cycle using the team's 64-bit logical-right-shift, set-less-than and related datapath units. It holds the result in an EX/MEM pipeline register with a valid/ready handshake for the memory stage, and keeps a retired-operation counter for performance monitoring.

## Interface
Parameters:
- XLEN, 64, datapath width.
- CNT_W, 32, width of the executed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  ID stage presents an operation.
- in_ready  output  1  EX can accept this cycle.
- in_op  input  4  ALU opcode (encoding under Operation).
- in_a  input  XLEN  operand A.
- in_b  input  XLEN  operand B (register or immediate, already selected).
- in_rd  input  5  destination register index.
- in_we  input  1  register write enable for this op.
- flush  input  1  kill the op held in the EX/MEM register and any op accepted this cycle.
- out_valid  output  1  EX/MEM register holds a valid result.
- out_ready  input  1  MEM stage consumes the result.
- out_result  output  XLEN  registered ALU result.
- out_rd  output  5  registered destination index.
- out_we  output  1  registered write enable, forced 0 when out_valid=0.
- out_zero  output  1  registered (result == 0).
- ex_count  output  CNT_W  number of operations accepted and not flushed.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SLL a<<b[4:0]; 6 SRL a>>b[4:0], zero-fill; 7 SRA a>>>b[4:0], sign-fill from a[XLEN-1]; 8 SLT signed, result {63'b0, a<b}; 9 SLTU unsigned; 10-15 reserved, result 0, out_we forced 0.
- Shift amount is b[4:0] only, range 0-31. b[XLEN-1:5] is ignored. Shift by 0 returns a unchanged.
- ADD/SUB wrap modulo 2^XLEN. No overflow flag.
- The ALU is combinational from in_*. The only state is the EX/MEM register and ex_count.
- in_ready = !out_valid || out_ready. This is combinational, with no dependency on in_valid.
- Accept occurs when in_valid && in_ready. On accept, the register loads result, rd, we and zero, and out_valid becomes 1.
- Drain occurs when out_valid && out_ready && no accept. out_valid becomes 0.
- Stall occurs when out_valid && !out_ready. The register and all out_* fields hold stable. in_ready is 0.
- Simultaneous drain and accept means back-to-back operation: the register loads the new op and out_valid stays 1.
- flush has priority over accept:
  - next cycle out_valid=0 and out_we=0;
  - an op offered in the same cycle is discarded and not counted;
  - out_result/out_rd/out_zero are don't-care while out_valid=0.
- ex_count increments by 1 on each accept without flush. It wraps from 2^CNT_W-1 to 0.
- Data fields are don't-care when out_valid=0. out_we must be 0.

## Timing
- Latency is 1 cycle: an op accepted at edge N is visible on out_* after edge N.
- Throughput is 1 op/cycle while out_ready=1.
- Reset values: out_valid=0, out_we=0, out_result=0, out_rd=0, out_zero=1, ex_count=0. in_ready=1 after reset.
- Reset mid-stall discards the held op. Reset wins over flush and accept in the same cycle.
- The combinational path in_a/in_b -> ALU -> register D must close in one cycle. The shifter mux tree is the critical path.
- No combinational path from in_* to out_*.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_we=0, ex_count=0, out_zero=1, in_ready=1.
- Shift boundaries:
  - SRL a=0x8000_0000_0000_0001, b=31 -> 0x0000_0001_0000_0000.
  - SRA same operands -> 0xFFFF_FFFF_0000_0000.
  - SRL b=0x40 (shamt 0) -> a unchanged.
  - SLL a=1, b=63 (shamt 31) -> 0x8000_0000.
- Arithmetic/compare:
  - SUB 0-1 -> 0xFFFF_FFFF_FFFF_FFFF with out_zero=0.
  - SLT a=-1, b=1 -> 1.
  - SLTU same operands -> 0.
  - XOR a=b -> 0 with out_zero=1.
- Backpressure: hold out_ready=0 for 3 cycles after accepting ADD 5+7.
  - out_result must stay 12 and in_ready=0 throughout.
  - Then out_ready=1 with a new op -> back-to-back load, out_valid stays 1.
- Flush: assert flush in the same cycle as an accept of ADD 1+1 -> next cycle out_valid=0, out_we=0, ex_count unchanged.
- Counter: preload CNT_W=4, stream 17 accepted ops -> ex_count=1 (wrap). Reserved opcode 12 -> result 0, out_we=0, still counted.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RISC-V pipeline.
// A combinational ALU feeds an EX/MEM pipeline register with a valid/ready
// handshake toward the memory stage, and a wrapping count of executed ops.
module ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [4:0]       in_rd,
    input  logic             in_we,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_zero,
    output logic [CNT_W-1:0] ex_count
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    // Only the low five bits of B ever steer the shifter.
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            op_legal;
    logic            accept;
    logic            drain;

    logic             valid_q,  valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       rd_q,     rd_d;
    logic             we_q,     we_d;
    logic             zero_q,   zero_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    assign shamt = in_b[4:0];

    // Ready depends only on register occupancy and downstream consumption,
    // never on in_valid, so ID can use it without a combinational loop.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q && out_ready && !accept;

    // ALU: purely combinational from the ID/EX operands.
    always_comb begin
        alu_res  = '0;
        op_legal = 1'b1;
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRL:  alu_res = in_a >> shamt;
            OP_SRA:  alu_res = $signed(in_a) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            default: begin
                // Reserved opcodes produce 0 and never write the register file.
                alu_res  = '0;
                op_legal = 1'b0;
            end
        endcase
    end

    // Next-state of the EX/MEM register: flush beats accept, accept beats drain.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        rd_d     = rd_q;
        we_d     = we_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            rd_d     = in_rd;
            we_d     = in_we && op_legal;
            zero_d   = (alu_res == '0);
        end else if (drain) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end
        if (accept && !flush) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State update; reset overrides flush and accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            zero_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    // we_q is cleared whenever valid drops, so out_we is already 0 while idle.
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign out_we     = we_q;
    assign out_zero   = zero_q;
    assign ex_count   = cnt_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven vectors plus hand-written stall/flush/reset
// sequences; expected results are queued when an op is accepted and
// popped when the memory stage consumes the output.
module tb_ex_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [4:0]       in_rd;
    logic             in_we;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [4:0]       out_rd;
    logic             out_we;
    logic             out_zero;
    logic [CNT_W-1:0] ex_count;

    ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .out_zero   (out_zero),
        .ex_count   (ex_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] res;
        logic        exp_we;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        zero;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    vec_t       vecs[16];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_cnt = 4'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [4:0] rd, input logic we, input logic [63:0] res,
                                input logic exp_we, input logic zero);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.we = we;
        v.res = res; v.exp_we = exp_we; v.zero = zero;
        return v;
    endfunction

    // Present one op for one edge; caller guarantees in_ready=1 so it is accepted.
    task automatic send(input vec_t v);
        exp_t x;
        in_valid = 1'b1;
        in_op = v.op; in_a = v.a; in_b = v.b; in_rd = v.rd; in_we = v.we;
        x.res = v.res; x.rd = v.rd; x.we = v.exp_we; x.zero = v.zero;
        sb.push_back(x);
        exp_cnt = exp_cnt + 4'd1;
        step();
    endtask

    // Scoreboard: compare each result in the cycle MEM consumes it.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result=%h expected no output", out_result);
            end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("rd", 64'(out_rd), 64'(e.rd));
                chk("we", 64'(out_we), 64'(e.we));
                chk("zero", 64'(out_zero), 64'(e.zero));
            end
        end
    end

    initial begin
        vecs[0]  = mk(4'd6,  64'h8000_0000_0000_0001, 64'd31, 5'd1, 1'b1, 64'h0000_0001_0000_0000, 1'b1, 1'b0);
        vecs[1]  = mk(4'd7,  64'h8000_0000_0000_0001, 64'd31, 5'd2, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0);
        vecs[2]  = mk(4'd6,  64'h1234_5678_9ABC_DEF0, 64'h40, 5'd3, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        vecs[3]  = mk(4'd5,  64'd1, 64'd63, 5'd4, 1'b1, 64'h0000_0000_8000_0000, 1'b1, 1'b0);
        vecs[4]  = mk(4'd1,  64'd0, 64'd1, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        vecs[5]  = mk(4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6, 1'b1, 64'd1, 1'b1, 1'b0);
        vecs[6]  = mk(4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 1'b1, 64'd0, 1'b1, 1'b1);
        vecs[7]  = mk(4'd4,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 5'd8, 1'b1, 64'd0, 1'b1, 1'b1);
        vecs[8]  = mk(4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9, 1'b1, 64'd1, 1'b1, 1'b0);
        vecs[9]  = mk(4'd2,  64'hF0F0, 64'hFF00, 5'd10, 1'b1, 64'hF000, 1'b1, 1'b0);
        vecs[10] = mk(4'd3,  64'hF0F0, 64'h0F00, 5'd11, 1'b0, 64'hFFF0, 1'b0, 1'b0);
        vecs[11] = mk(4'd12, 64'h55, 64'h66, 5'd12, 1'b1, 64'd0, 1'b0, 1'b1);
        vecs[12] = mk(4'd8,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 1'b1, 64'd0, 1'b1, 1'b1);
        vecs[13] = mk(4'd9,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 1'b1, 64'd1, 1'b1, 1'b0);
        vecs[14] = mk(4'd7,  64'h4000_0000_0000_0000, 64'd4, 5'd15, 1'b1, 64'h0400_0000_0000_0000, 1'b1, 1'b0);
        vecs[15] = mk(4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'h21, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

        // Reset for two cycles while ID offers an op.
        rst = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_a = 64'd3; in_b = 64'd4;
        in_rd = 5'd9; in_we = 1'b1; flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_we", 64'(out_we), 64'd0);
        chk("rst_ex_count", 64'(ex_count), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", out_result, 64'd0);
        step();
        rst = 1'b0; in_valid = 1'b0;

        // 17 back-to-back accepted ops wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            send(mk(4'd0, 64'(i), 64'(i), 5'(i), 1'b1, 64'(2 * i), 1'b1, (i == 0)));
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("count_wrap", 64'(ex_count), 64'd1);

        // Table of ALU vectors streamed at full throughput.
        step();
        for (int i = 0; i < 16; i++) begin
            send(vecs[i]);
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("count_after_table", 64'(ex_count), 64'(exp_cnt));
        chk("table_drained", 64'(sb.size()), 64'd0);

        // Backpressure: hold ADD 5+7 for three cycles, then back-to-back load.
        step();
        out_ready = 1'b0;
        send(mk(4'd0, 64'd5, 64'd7, 5'd3, 1'b1, 64'd12, 1'b1, 1'b0));
        in_valid = 1'b1; in_op = 4'd1; in_a = 64'd9; in_b = 64'd4; in_rd = 5'd4; in_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_result", out_result, 64'd12);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        e.res = 64'd5; e.rd = 5'd4; e.we = 1'b1; e.zero = 1'b0;
        sb.push_back(e);
        exp_cnt = exp_cnt + 4'd1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_result", out_result, 64'd5);
        step();

        // Flush in the same cycle as an accept of ADD 1+1.
        in_valid = 1'b1; in_op = 4'd0; in_a = 64'd1; in_b = 64'd1; in_rd = 5'd7; in_we = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_we", 64'(out_we), 64'd0);
        chk("flush_count", 64'(ex_count), 64'(exp_cnt));

        // Flush of an op stalled in the EX/MEM register.
        step();
        out_ready = 1'b0;
        send(mk(4'd0, 64'd2, 64'd3, 5'd8, 1'b1, 64'd5, 1'b1, 1'b0));
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("flush_held_valid", 64'(out_valid), 64'd0);
        chk("flush_held_we", 64'(out_we), 64'd0);
        chk("flush_held_count", 64'(ex_count), 64'(exp_cnt));

        // Reset mid-stall, with flush and an offered op in the same cycle.
        step();
        send(mk(4'd0, 64'd4, 64'd4, 5'd2, 1'b1, 64'd8, 1'b1, 1'b0));
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        void'(sb.pop_back());
        exp_cnt = 4'd0;
        @(negedge clk);
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_count", 64'(ex_count), 64'd0);
        chk("rst_stall_zero", 64'(out_zero), 64'd1);
        chk("rst_stall_in_ready", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b1;

        // Counting restarts from zero after reset.
        send(mk(4'd2, 64'hFF, 64'h0F, 5'd1, 1'b1, 64'h0F, 1'b1, 1'b0));
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("count_after_rst", 64'(ex_count), 64'd1);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
